// File: rtl/phosphor_decay_blender.sv
// phosphor_decay_blender
// Three-stage pipeline that blends eight ring-buffer phosphor taps into one
// scan-out intensity at the current raster position.
//   stage 1: per-tap hit test and per-tap decay shift
//   stage 2: partial combine over taps 0-3 and 4-7, partial hit counts
//   stage 3: final combine, 12-bit intensity, total hit count
// Build option: define PHOSPHOR_SUM_EN to combine taps by saturating sum
// instead of max. Latency, interface and hit counting do not change.
module phosphor_decay_blender #(
    parameter int MATCH_RADIUS = 1,
    parameter int DECAY_STEP   = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [255:0] taps,
    input  logic [9:0]   raster_x,
    input  logic [9:0]   raster_y,
    input  logic         raster_valid,
    output logic [7:0]   luma_out,
    output logic         luma_valid,
    output logic [3:0]   hit_count
);

`ifdef PHOSPHOR_SUM_EN
    // Four 12-bit terms fit in 14 bits, so partial sums never overflow.
    localparam int PART_W = 14;
`else
    localparam int PART_W = 12;
`endif

    logic [7:0]        w_tap_hit;
    logic [11:0]       w_tap_w [8];

    logic              r_s1_valid;
    logic [7:0]        r_s1_hit;
    logic [11:0]       r_s1_w [8];

    logic [PART_W-1:0] w_part_lo;
    logic [PART_W-1:0] w_part_hi;
    logic [2:0]        w_cnt_lo;
    logic [2:0]        w_cnt_hi;

    logic              r_s2_valid;
    logic [PART_W-1:0] r_part_lo;
    logic [PART_W-1:0] r_part_hi;
    logic [2:0]        r_cnt_lo;
    logic [2:0]        r_cnt_hi;

    logic [11:0]       w_int;
    logic [3:0]        w_cnt;

    logic              r_s3_valid;
    logic [11:0]       r_s3_int;
    logic [3:0]        r_s3_cnt;

    logic              w_unused_lsb;

    // Per-tap hit test. Differences are taken as plain magnitudes so that
    // coordinates never wrap between column 0 and column 1023.
    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_tap
            logic [9:0]  w_x;
            logic [9:0]  w_y;
            logic [11:0] w_l;
            logic [10:0] w_dx;
            logic [10:0] w_dy;

            assign w_y  = taps[32*k+22 +: 10];
            assign w_x  = taps[32*k+12 +: 10];
            assign w_l  = taps[32*k    +: 12];
            assign w_dx = (w_x >= raster_x) ? ({1'b0, w_x} - {1'b0, raster_x})
                                            : ({1'b0, raster_x} - {1'b0, w_x});
            assign w_dy = (w_y >= raster_y) ? ({1'b0, w_y} - {1'b0, raster_y})
                                            : ({1'b0, raster_y} - {1'b0, w_y});
            assign w_tap_hit[k] = (w_l != '0)
                                && (w_dx <= 11'(MATCH_RADIUS))
                                && (w_dy <= 11'(MATCH_RADIUS));
            // Older taps are dimmer: each tap index adds DECAY_STEP of shift.
            assign w_tap_w[k] = w_tap_hit[k] ? (w_l >> (k * DECAY_STEP)) : 12'd0;
        end
    endgenerate

    // Stage 1: register hit flags and decayed weights.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= '0;
            for (int i = 0; i < 8; i++) r_s1_w[i] <= '0;
        end else begin
            r_s1_valid <= raster_valid;
            r_s1_hit   <= w_tap_hit;
            for (int i = 0; i < 8; i++) r_s1_w[i] <= w_tap_w[i];
        end
    end

    // Stage 2 combine: non-hit weights are already zero, so they drop out of
    // both max and sum without extra masking.
    always_comb begin
        w_part_lo = '0;
        w_part_hi = '0;
        w_cnt_lo  = '0;
        w_cnt_hi  = '0;
        for (int i = 0; i < 4; i++) begin
            w_cnt_lo = w_cnt_lo + 3'(r_s1_hit[i]);
            w_cnt_hi = w_cnt_hi + 3'(r_s1_hit[i+4]);
`ifdef PHOSPHOR_SUM_EN
            w_part_lo = w_part_lo + PART_W'(r_s1_w[i]);
            w_part_hi = w_part_hi + PART_W'(r_s1_w[i+4]);
`else
            if (r_s1_w[i]   > w_part_lo) w_part_lo = r_s1_w[i];
            if (r_s1_w[i+4] > w_part_hi) w_part_hi = r_s1_w[i+4];
`endif
        end
    end

    // Stage 2: register partial results and partial hit counts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_part_lo  <= '0;
            r_part_hi  <= '0;
            r_cnt_lo   <= '0;
            r_cnt_hi   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_part_lo  <= w_part_lo;
            r_part_hi  <= w_part_hi;
            r_cnt_lo   <= w_cnt_lo;
            r_cnt_hi   <= w_cnt_hi;
        end
    end

    // Stage 3 combine: final max, or 15-bit sum saturated to 12 bits.
`ifdef PHOSPHOR_SUM_EN
    logic [14:0] w_sum;
    always_comb begin
        w_sum = {1'b0, r_part_lo} + {1'b0, r_part_hi};
        w_int = (w_sum > 15'd4095) ? 12'hFFF : w_sum[11:0];
    end
`else
    always_comb begin
        w_int = (r_part_lo > r_part_hi) ? r_part_lo : r_part_hi;
    end
`endif

    assign w_cnt = {1'b0, r_cnt_lo} + {1'b0, r_cnt_hi};

    // Stage 3: register intensity and total hit count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s3_valid <= 1'b0;
            r_s3_int   <= '0;
            r_s3_cnt   <= '0;
        end else begin
            r_s3_valid <= r_s2_valid;
            r_s3_int   <= w_int;
            r_s3_cnt   <= w_cnt;
        end
    end

    // Only the top eight intensity bits reach the display.
    assign w_unused_lsb = ^r_s3_int[3:0];

    assign luma_valid = r_s3_valid;
    assign luma_out   = r_s3_valid ? r_s3_int[11:4] : 8'd0;
    assign hit_count  = r_s3_valid ? r_s3_cnt : 4'd0;

endmodule

// File: tb/tb_phosphor_decay_blender.sv
// Testbench for phosphor_decay_blender: directed cases plus randomized
// stimulus checked against a per-pixel arithmetic model. Define
// PHOSPHOR_SUM_EN for both DUT and bench to check the sum build.
module tb_phosphor_decay_blender;

    localparam int MR = 1;
    localparam int DS = 1;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [255:0] taps;
    logic [9:0]   raster_x;
    logic [9:0]   raster_y;
    logic         raster_valid;
    logic [7:0]   luma_out;
    logic         luma_valid;
    logic [3:0]   hit_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bit ev [0:4095];
    int el_a [0:4095];
    int eh_a [0:4095];

    phosphor_decay_blender #(.MATCH_RADIUS(MR), .DECAY_STEP(DS)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .taps         (taps),
        .raster_x     (raster_x),
        .raster_y     (raster_y),
        .raster_valid (raster_valid),
        .luma_out     (luma_out),
        .luma_valid   (luma_valid),
        .hit_count    (hit_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_tap(input int y, input int x, input int l);
        logic [31:0] t;
        t = {y[9:0], x[9:0], l[11:0]};
        return t;
    endfunction

    // Reference: brightness of the pixel at (rx, ry) as the strongest (or
    // total, saturated) decayed luma of all nearby lit taps.
    task automatic model(input logic [255:0] t, input int rx, input int ry,
                         output int el, output int eh);
        int x, y, l, dx, dy, w, mx, sm, inten;
        mx = 0; sm = 0; eh = 0;
        for (int k = 0; k < 8; k++) begin
            y = int'(t[32*k+22 +: 10]);
            x = int'(t[32*k+12 +: 10]);
            l = int'(t[32*k +: 12]);
            dx = (x > rx) ? x - rx : rx - x;
            dy = (y > ry) ? y - ry : ry - y;
            if (l != 0 && dx <= MR && dy <= MR) begin
                eh++;
                w = l / (2 ** (k * DS));
                sm += w;
                if (w > mx) mx = w;
            end
        end
`ifdef PHOSPHOR_SUM_EN
        inten = (sm > 4095) ? 4095 : sm;
`else
        inten = mx;
`endif
        el = inten / 16;
    endtask

    task automatic check_out();
        int idx;
        idx = cyc - 3;
        if (idx >= 0 && ev[idx]) begin
            chk("luma_valid", {31'd0, luma_valid}, 32'd1);
            chk("luma_out",   {24'd0, luma_out},   el_a[idx]);
            chk("hit_count",  {28'd0, hit_count},  eh_a[idx]);
        end else begin
            chk("luma_valid_idle", {31'd0, luma_valid}, 32'd0);
            chk("luma_out_idle",   {24'd0, luma_out},   32'd0);
            chk("hit_count_idle",  {28'd0, hit_count},  32'd0);
        end
    endtask

    task automatic step(input logic v, input logic [255:0] t, input int rx, input int ry);
        int el, eh;
        @(negedge clock);
        check_out();
        reset_n      = 1'b1;
        taps         = t;
        raster_x     = rx[9:0];
        raster_y     = ry[9:0];
        raster_valid = v;
        model(t, rx, ry, el, eh);
        ev[cyc]   = v;
        el_a[cyc] = el;
        eh_a[cyc] = eh;
        cyc++;
    endtask

    // One-cycle reset pulse: everything still inside the pipeline is lost.
    task automatic reset_pulse();
        @(negedge clock);
        check_out();
        reset_n      = 1'b0;
        raster_valid = 1'b0;
        ev[cyc] = 1'b0;
        if (cyc >= 1) ev[cyc-1] = 1'b0;
        if (cyc >= 2) ev[cyc-2] = 1'b0;
        cyc++;
        #1;
        chk("rst_luma_valid", {31'd0, luma_valid}, 32'd0);
        chk("rst_luma_out",   {24'd0, luma_out},   32'd0);
        chk("rst_hit_count",  {28'd0, hit_count},  32'd0);
    endtask

    function automatic int near(input int c);
        int d, r;
        d = int'($urandom_range(0, 6)) - 3;
        r = c + d;
        if (r < 0) r = 0;
        if (r > 1023) r = 1023;
        return r;
    endfunction

    function automatic logic [255:0] rand_taps(input int rx, input int ry);
        logic [255:0] t;
        int x, y, l;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 2) != 0) begin
                x = near(rx);
                y = near(ry);
            end else begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 1023));
            end
            case ($urandom_range(0, 5))
                0:       l = 0;
                1:       l = 4095;
                default: l = int'($urandom_range(0, 4095));
            endcase
            t[32*k +: 32] = mk_tap(y, x, l);
        end
        return t;
    endfunction

    initial begin
        logic [255:0] t;
        int rx, ry;

        reset_n      = 1'b0;
        taps         = '0;
        raster_x     = '0;
        raster_y     = '0;
        raster_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("reset_luma_valid", {31'd0, luma_valid}, 32'd0);
        chk("reset_luma_out",   {24'd0, luma_out},   32'd0);
        chk("reset_hit_count",  {28'd0, hit_count},  32'd0);

        // Single bright tap: centre, just outside radius, diagonal neighbour.
        t = '0;
        t[31:0] = mk_tap(100, 200, 'hFFF);
        step(1'b1, t, 200, 100);
        step(1'b1, t, 202, 100);
        step(1'b1, t, 201, 99);

        // Eight identical taps on one pixel.
        t = '0;
        for (int k = 0; k < 8; k++) t[32*k +: 32] = mk_tap(5, 5, 'h800);
        step(1'b1, t, 5, 5);

        // Screen-edge: no wrap from column 1023 back to 0.
        t = '0;
        t[31:0] = mk_tap(0, 0, 'h400);
        step(1'b1, t, 1023, 0);
        step(1'b1, t, 1, 1);

        // Luma-zero tap never hits.
        t = '0;
        t[63:32] = mk_tap(50, 50, 0);
        step(1'b1, t, 50, 50);

        // Ten-input stream with a bubble at input 4.
        for (int i = 0; i < 10; i++) begin
            rx = int'($urandom_range(0, 1023));
            ry = int'($urandom_range(0, 1023));
            step(i != 4, rand_taps(rx, ry), rx, ry);
        end

        // Reset pulse with three results in flight.
        for (int i = 0; i < 3; i++) begin
            rx = int'($urandom_range(0, 1023));
            ry = int'($urandom_range(0, 1023));
            step(1'b1, rand_taps(rx, ry), rx, ry);
        end
        reset_pulse();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 0, 0);

        // Randomized traffic with an occasional bubble and one more reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) reset_pulse();
            rx = int'($urandom_range(0, 1023));
            ry = int'($urandom_range(0, 1023));
            step($urandom_range(0, 7) != 0, rand_taps(rx, ry), rx, ry);
        end

        for (int i = 0; i < 4; i++) step(1'b0, '0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
